// File: rtl/machining_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : machining_sequencer
//  Purpose  : Run/stop sequencer for the pulse generator (mos_control).
//             Holds a one-deep shadow parameter register. Each new set is
//             copied to the active outputs at a safe point, so a pulse never
//             sees its parameters change while it is in progress. The block
//             also enters a cooldown after a run of short-circuit pulses,
//             and drains the current pulse on a host stop.
//  Ports    : clk, rst_n           - 100 MHz clock, async active-low reset
//             host_start/host_stop - one-cycle host requests
//             cmd_valid/cmd_ready  - parameter-set handshake
//             cmd_waveform/Ip/Ton/Toff - offered parameter set (16b each)
//             pulse_end            - end-of-Toff strobe from mos_control
//             short_detect         - qualifies pulse_end as a short circuit
//             is_machine_start     - registered enable to mos_control
//             waveform/Ip/Ton/Toff - active parameter set (registered)
//             param_applied        - one-cycle strobe on shadow->active copy
//             state                - FSM state (IDLE=0 RUN=1 DRAIN=2 COOLDOWN=3)
//             drain_timeout_err    - sticky; cleared by the next host_start
//             pulse_count/short_total - statistics (zero unless enabled)
//  Config   : define PULSE_STAT_EN to build the statistics counters
//  Revision : 1.0 - initial release
// ============================================================================
module machining_sequencer #(
    parameter logic [15:0] SHORT_LIMIT     = 16'd8,
    parameter logic [15:0] COOLDOWN_CYCLES = 16'd1000,
    parameter logic [15:0] DRAIN_TIMEOUT   = 16'd5000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        host_start,
    input  logic        host_stop,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_waveform,
    input  logic [15:0] cmd_Ip,
    input  logic [15:0] cmd_Ton,
    input  logic [15:0] cmd_Toff,
    input  logic        pulse_end,
    input  logic        short_detect,
    output logic        is_machine_start,
    output logic [15:0] waveform,
    output logic [15:0] Ip,
    output logic [15:0] Ton,
    output logic [15:0] Toff,
    output logic        param_applied,
    output logic [1:0]  state,
    output logic        drain_timeout_err,
    output logic [31:0] pulse_count,
    output logic [15:0] short_total
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_RUN      = 2'd1;
    localparam logic [1:0] S_DRAIN    = 2'd2;
    localparam logic [1:0] S_COOLDOWN = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [15:0] short_run_q, short_run_d;
    logic        err_q, err_d;

    logic        shadow_full_q, shadow_full_d;
    logic [15:0] sh_wf_q, sh_wf_d, sh_ip_q, sh_ip_d;
    logic [15:0] sh_ton_q, sh_ton_d, sh_toff_q, sh_toff_d;
    logic [15:0] wf_q, wf_d, ip_q, ip_d, ton_q, ton_d, toff_q, toff_d;
    logic        applied_q, applied_d;
    logic        start_q, start_d;

    // 17-bit arithmetic keeps the limit compares safe for any parameter value
    logic [16:0] timer_next;
    logic        timer_done;
    logic [16:0] short_inc;
    logic        short_hit;
    logic        do_copy;
    logic        do_capture;

    assign timer_next = {1'b0, timer_q} + 17'd1;
    assign short_inc  = {1'b0, short_run_q} + 17'd1;
    assign short_hit  = (short_inc >= {1'b0, SHORT_LIMIT});

    always_comb begin
        timer_done = 1'b0;
        if (state_q == S_DRAIN) begin
            timer_done = (timer_next >= {1'b0, DRAIN_TIMEOUT});
        end else if (state_q == S_COOLDOWN) begin
            timer_done = (timer_next >= {1'b0, COOLDOWN_CYCLES});
        end
    end

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            timer_q       <= 16'd0;
            short_run_q   <= 16'd0;
            err_q         <= 1'b0;
            shadow_full_q <= 1'b0;
            sh_wf_q       <= 16'd0;
            sh_ip_q       <= 16'd0;
            sh_ton_q      <= 16'd0;
            sh_toff_q     <= 16'd0;
            wf_q          <= 16'd0;
            ip_q          <= 16'd0;
            ton_q         <= 16'd0;
            toff_q        <= 16'd0;
            applied_q     <= 1'b0;
            start_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            short_run_q   <= short_run_d;
            err_q         <= err_d;
            shadow_full_q <= shadow_full_d;
            sh_wf_q       <= sh_wf_d;
            sh_ip_q       <= sh_ip_d;
            sh_ton_q      <= sh_ton_d;
            sh_toff_q     <= sh_toff_d;
            wf_q          <= wf_d;
            ip_q          <= ip_d;
            ton_q         <= ton_d;
            toff_q        <= toff_d;
            applied_q     <= applied_d;
            start_q       <= start_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d     = state_q;
        short_run_d = short_run_q;
        err_d       = err_q;

        case (state_q)
            S_IDLE: begin
                // stop wins over a simultaneous start
                if (host_start && !host_stop) begin
                    state_d = S_RUN;
                    err_d   = 1'b0;
                end
            end
            S_RUN: begin
                if (pulse_end) begin
                    if (short_detect && !short_hit) begin
                        short_run_d = short_inc[15:0];
                    end else begin
                        short_run_d = 16'd0;
                    end
                end
                if (host_stop) begin
                    state_d = S_DRAIN;
                end else if (pulse_end && short_detect && short_hit) begin
                    state_d = S_COOLDOWN;
                end
            end
            S_DRAIN: begin
                if (pulse_end) begin
                    state_d = S_IDLE;
                end else if (timer_done) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            S_COOLDOWN: begin
                if (host_stop) begin
                    state_d = S_IDLE;
                end else if (timer_done) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Timer restarts from zero on every state change, so each timed
        // state lasts exactly its configured number of cycles.
        if (state_d != state_q) begin
            timer_d = 16'd0;
        end else if ((state_q == S_DRAIN) || (state_q == S_COOLDOWN)) begin
            timer_d = timer_next[15:0];
        end else begin
            timer_d = 16'd0;
        end
    end

    // ---------------------------------------------------------------- outputs / datapath
    // While running, the copy waits for the pulse_end edge so mos_control
    // only picks up new parameters between pulses.
    assign do_copy    = shadow_full_q && ((state_q != S_RUN) || pulse_end);
    assign do_capture = cmd_valid && !shadow_full_q;

    always_comb begin
        start_d       = (state_d == S_RUN);
        shadow_full_d = shadow_full_q;
        sh_wf_d       = sh_wf_q;
        sh_ip_d       = sh_ip_q;
        sh_ton_d      = sh_ton_q;
        sh_toff_d     = sh_toff_q;
        wf_d          = wf_q;
        ip_d          = ip_q;
        ton_d         = ton_q;
        toff_d        = toff_q;
        applied_d     = 1'b0;

        if (do_capture) begin
            shadow_full_d = 1'b1;
            sh_wf_d       = cmd_waveform;
            sh_ip_d       = cmd_Ip;
            sh_ton_d      = cmd_Ton;
            sh_toff_d     = cmd_Toff;
        end else if (do_copy) begin
            shadow_full_d = 1'b0;
            wf_d          = sh_wf_q;
            ip_d          = sh_ip_q;
            ton_d         = sh_ton_q;
            toff_d        = sh_toff_q;
            applied_d     = 1'b1;
        end
    end

    assign cmd_ready         = !shadow_full_q;
    assign is_machine_start  = start_q;
    assign waveform          = wf_q;
    assign Ip                = ip_q;
    assign Ton               = ton_q;
    assign Toff              = toff_q;
    assign param_applied     = applied_q;
    assign state             = state_q;
    assign drain_timeout_err = err_q;

    // ---------------------------------------------------------------- statistics
`ifdef PULSE_STAT_EN
    logic [31:0] pulse_count_q, pulse_count_d;
    logic [15:0] short_total_q, short_total_d;
    logic        run_pulse;

    assign run_pulse = (state_q == S_RUN) && pulse_end;

    always_comb begin
        pulse_count_d = pulse_count_q;
        short_total_d = short_total_q;
        if (run_pulse) begin
            pulse_count_d = pulse_count_q + 32'd1;
            if (short_detect && (short_total_q != 16'hFFFF)) begin
                short_total_d = short_total_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_count_q <= 32'd0;
            short_total_q <= 16'd0;
        end else begin
            pulse_count_q <= pulse_count_d;
            short_total_q <= short_total_d;
        end
    end

    assign pulse_count = pulse_count_q;
    assign short_total = short_total_q;
`else
    assign pulse_count = 32'd0;
    assign short_total = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_machining_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_machining_sequencer
//  Purpose  : Directed self-checking bench for machining_sequencer with
//             default parameters (limit 8, cooldown 1000, drain 5000).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_machining_sequencer;

`ifdef PULSE_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        host_start, host_stop, cmd_valid, cmd_ready;
    logic [15:0] cmd_waveform, cmd_Ip, cmd_Ton, cmd_Toff;
    logic        pulse_end, short_detect, is_machine_start;
    logic [15:0] waveform, Ip, Ton, Toff;
    logic        param_applied;
    logic [1:0]  state;
    logic        drain_timeout_err;
    logic [31:0] pulse_count;
    logic [15:0] short_total;

    int n_tests = 0;
    int n_fail  = 0;
    int bad;

    always #5 clk = ~clk;

    machining_sequencer dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .host_start        (host_start),
        .host_stop         (host_stop),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_waveform      (cmd_waveform),
        .cmd_Ip            (cmd_Ip),
        .cmd_Ton           (cmd_Ton),
        .cmd_Toff          (cmd_Toff),
        .pulse_end         (pulse_end),
        .short_detect      (short_detect),
        .is_machine_start  (is_machine_start),
        .waveform          (waveform),
        .Ip                (Ip),
        .Ton               (Ton),
        .Toff              (Toff),
        .param_applied     (param_applied),
        .state             (state),
        .drain_timeout_err (drain_timeout_err),
        .pulse_count       (pulse_count),
        .short_total       (short_total)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_ims"},   32'(is_machine_start), 32'd0);
        chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_appl"},  32'(param_applied), 32'd0);
        chk({tag, "_err"},   32'(drain_timeout_err), 32'd0);
        chk({tag, "_set"},   {waveform | Ip, Ton | Toff}, 32'd0);
        chk({tag, "_pcnt"},  pulse_count, 32'd0);
        chk({tag, "_stot"},  32'(short_total), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; host_start = 1'b0; host_stop = 1'b0; cmd_valid = 1'b0;
        cmd_waveform = 16'd0; cmd_Ip = 16'd0; cmd_Ton = 16'd0; cmd_Toff = 16'd0;
        pulse_end = 1'b0; short_detect = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk_reset_values("reset");

        // ---- load in IDLE: capture, copy one cycle later
        cmd_valid = 1'b1; cmd_waveform = 16'd1; cmd_Ip = 16'd100; cmd_Ton = 16'd30; cmd_Toff = 16'd20;
        tick();
        cmd_valid = 1'b0;
        chk("cap_ready", 32'(cmd_ready), 32'd0);
        chk("cap_appl",  32'(param_applied), 32'd0);
        tick();
        chk("copy_appl", 32'(param_applied), 32'd1);
        chk("copy_wf",   32'(waveform), 32'd1);
        chk("copy_ip",   32'(Ip), 32'd100);
        chk("copy_ton",  32'(Ton), 32'd30);
        chk("copy_toff", 32'(Toff), 32'd20);
        chk("copy_ready", 32'(cmd_ready), 32'd1);
        tick();
        chk("appl_1cyc", 32'(param_applied), 32'd0);

        // ---- start
        host_start = 1'b1; tick(); host_start = 1'b0;
        chk("start_state", 32'(state), 32'd1);
        chk("start_ims",   32'(is_machine_start), 32'd1);

        // ---- mid-pulse load held until pulse_end
        cmd_valid = 1'b1; cmd_Ton = 16'd40;
        tick();
        cmd_valid = 1'b0;
        chk("mid_ready", 32'(cmd_ready), 32'd0);
        repeat (3) tick();
        chk("mid_ton_hold", 32'(Ton), 32'd30);
        chk("mid_ready2",   32'(cmd_ready), 32'd0);
        chk("mid_appl",     32'(param_applied), 32'd0);
        pulse_end = 1'b1; tick(); pulse_end = 1'b0;
        chk("pe_ton",   32'(Ton), 32'd40);
        chk("pe_appl",  32'(param_applied), 32'd1);
        chk("pe_ready", 32'(cmd_ready), 32'd1);

        // ---- 7 shorts + 1 clean: no cooldown
        pulse_end = 1'b1; short_detect = 1'b1;
        repeat (7) tick();
        short_detect = 1'b0;
        tick();
        pulse_end = 1'b0;
        tick();
        chk("7s1c_state", 32'(state), 32'd1);
        chk("7s1c_pcnt", pulse_count, STAT ? 32'd9 : 32'd0);

        // ---- 8 shorts: cooldown
        pulse_end = 1'b1; short_detect = 1'b1;
        repeat (7) tick();
        chk("7s_state", 32'(state), 32'd1);
        tick();
        pulse_end = 1'b0; short_detect = 1'b0;
        chk("cd_state", 32'(state), 32'd3);
        chk("cd_ims",   32'(is_machine_start), 32'd0);
        bad = 0;
        for (int i = 0; i < 999; i++) begin
            // a stray pulse_end during cooldown must be ignored
            pulse_end = (i == 500); short_detect = (i == 500);
            tick();
            if (state !== 2'd3 || is_machine_start !== 1'b0) bad++;
        end
        pulse_end = 1'b0; short_detect = 1'b0;
        chk("cd_len_hold", 32'(bad), 32'd0);
        tick();
        chk("cd_end_state", 32'(state), 32'd1);
        chk("cd_end_ims",   32'(is_machine_start), 32'd1);
        chk("cd_pcnt", pulse_count, STAT ? 32'd17 : 32'd0);
        chk("cd_stot", 32'(short_total), STAT ? 32'd15 : 32'd0);

        // ---- stop, pulse_end 200 cycles later
        host_stop = 1'b1; tick(); host_stop = 1'b0;
        chk("drain_state", 32'(state), 32'd2);
        chk("drain_ims",   32'(is_machine_start), 32'd0);
        repeat (199) tick();
        chk("drain_hold", 32'(state), 32'd2);
        pulse_end = 1'b1; tick(); pulse_end = 1'b0;
        chk("drain_idle", 32'(state), 32'd0);
        chk("drain_err0", 32'(drain_timeout_err), 32'd0);
        chk("drain_pcnt", pulse_count, STAT ? 32'd17 : 32'd0);

        // ---- host_stop in IDLE ignored
        host_stop = 1'b1; tick(); host_stop = 1'b0;
        chk("idle_stop", 32'(state), 32'd0);

        // ---- drain timeout
        host_start = 1'b1; tick(); host_start = 1'b0;
        host_stop = 1'b1; tick(); host_stop = 1'b0;
        chk("to_drain", 32'(state), 32'd2);
        repeat (4999) tick();
        chk("to_hold",  32'(state), 32'd2);
        chk("to_err0",  32'(drain_timeout_err), 32'd0);
        tick();
        chk("to_idle",  32'(state), 32'd0);
        chk("to_err1",  32'(drain_timeout_err), 32'd1);
        host_start = 1'b1; tick(); host_start = 1'b0;
        chk("to_restart", 32'(state), 32'd1);
        chk("to_errclr",  32'(drain_timeout_err), 32'd0);

        // ---- back to IDLE, then simultaneous start/stop
        host_stop = 1'b1; tick(); host_stop = 1'b0;
        pulse_end = 1'b1; tick(); pulse_end = 1'b0;
        chk("back_idle", 32'(state), 32'd0);
        host_start = 1'b1; host_stop = 1'b1; tick(); host_start = 1'b0; host_stop = 1'b0;
        chk("both_state", 32'(state), 32'd0);
        chk("both_ims",   32'(is_machine_start), 32'd0);

        // ---- async reset mid-RUN with a pending shadow
        host_start = 1'b1; tick(); host_start = 1'b0;
        cmd_valid = 1'b1; cmd_Ton = 16'd77; tick(); cmd_valid = 1'b0;
        chk("pre_rst_ims",   32'(is_machine_start), 32'd1);
        chk("pre_rst_ready", 32'(cmd_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_values("async_rst");
        #1 rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_appl", 32'(param_applied), 32'd0);
        chk("post_rst_ton",  32'(Ton), 32'd0);

        // ---- 10 clean pulses counted
        host_start = 1'b1; tick(); host_start = 1'b0;
        pulse_end = 1'b1; repeat (10) tick(); pulse_end = 1'b0;
        tick();
        chk("stat_10", pulse_count, STAT ? 32'd10 : 32'd0);
        chk("stat_run", 32'(state), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/machining_sequencer.md
MACHINING_SEQUENCER -- requirements
Module: machining_sequencer

Interface
REQ-001 Parameter SHORT_LIMIT, default 16'd8, consecutive short pulses that trigger cooldown.
REQ-002 Parameter COOLDOWN_CYCLES, default 16'd1000, cooldown length in clk cycles.
REQ-003 Parameter DRAIN_TIMEOUT, default 16'd5000, maximum cycles to wait for pulse_end after stop.
REQ-004 clk  in  1  system clock, 100 MHz.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 host_start  in  1  one-cycle start request.
REQ-007 host_stop  in  1  one-cycle stop request.
REQ-008 cmd_valid  in  1  new parameter set offered.
REQ-009 cmd_ready  out  1  shadow register empty; may accept a set.
REQ-010 cmd_waveform, cmd_Ip, cmd_Ton, cmd_Toff  in  16 each  offered parameter set.
REQ-011 pulse_end  in  1  one-cycle strobe from mos_control at end of each Toff.
REQ-012 short_detect  in  1  qualifies pulse_end: the pulse was a short circuit.
REQ-013 is_machine_start  out  1  enable to mos_control, registered.
REQ-014 waveform, Ip, Ton, Toff  out  16 each  active parameter set to mos_control, registered.
REQ-015 param_applied  out  1  one-cycle strobe when the shadow set is copied to the active set.
REQ-016 state  out  2  current FSM state encoding.
REQ-017 drain_timeout_err  out  1  sticky error flag.
REQ-018 pulse_count  out  32 and short_total  out  16  statistics (see Configuration).

Function
REQ-019 The FSM SHALL have states IDLE=0, RUN=1, DRAIN=2, COOLDOWN=3; is_machine_start SHALL be 1 only in RUN.
REQ-020 IDLE: host_start SHALL move the FSM to RUN on the next edge, and SHALL clear drain_timeout_err.
REQ-021 A set SHALL be captured when cmd_valid and cmd_ready are both high; cmd_ready SHALL drop the following cycle; no capture while the shadow is full.
REQ-022 In IDLE, DRAIN and COOLDOWN, a full shadow SHALL be copied to the active set one cycle after capture.
REQ-023 In RUN, a full shadow SHALL be copied only on the edge where pulse_end=1, so mos_control never sees a mid-pulse change.
REQ-024 Each copy SHALL assert param_applied for exactly one cycle; cmd_ready SHALL return high the cycle after the copy.
REQ-025 RUN + host_stop SHALL go to DRAIN; DRAIN SHALL go to IDLE on pulse_end, or after DRAIN_TIMEOUT cycles with drain_timeout_err set.
REQ-026 In RUN, short_run SHALL increment on pulse_end with short_detect=1 and clear on pulse_end with short_detect=0.
REQ-027 When short_run reaches SHORT_LIMIT, the FSM SHALL enter COOLDOWN and clear short_run.
REQ-028 COOLDOWN SHALL last COOLDOWN_CYCLES cycles, then return to RUN.
REQ-029 host_stop in COOLDOWN SHALL go to IDLE directly; host_stop in IDLE SHALL be ignored.
REQ-030 If host_start and host_stop are asserted in the same cycle, host_stop SHALL win; host_start outside IDLE SHALL be ignored.
REQ-031 short_detect without pulse_end SHALL be ignored; pulse_end outside RUN/DRAIN SHALL have no effect.

Reset
REQ-032 On rst_n low: state=IDLE; is_machine_start=0; active set and shadow = 0; shadow empty; cmd_ready=1; param_applied=0; drain_timeout_err=0; all counters = 0.
REQ-033 Reset mid-pulse SHALL drop is_machine_start immediately (asynchronously) and discard any pending shadow.

Configuration
REQ-034 With macro PULSE_STAT_EN defined, pulse_count SHALL increment on every pulse_end in RUN (wrapping at 2^32).
REQ-035 With PULSE_STAT_EN defined, short_total SHALL increment on short pulses and saturate at 16'hFFFF.
REQ-036 Without PULSE_STAT_EN, both statistics outputs SHALL be constant 0 and their counters SHALL not be synthesized.

Verification
REQ-037 Load (wf=1, Ip=100, Ton=30, Toff=20) in IDLE -> param_applied 1 cycle later; outputs match; host_start -> is_machine_start=1 in 1 cycle.
REQ-038 In RUN, load Ton=40 mid-pulse -> Ton stays 30 until the pulse_end edge, then 40; cmd_ready low throughout.
REQ-039 8 consecutive pulse_end with short_detect=1 -> COOLDOWN, is_machine_start=0 for 1000 cycles, then RUN; 7 shorts + 1 clean -> no cooldown.
REQ-040 host_stop in RUN, pulse_end 200 cycles later -> IDLE; no pulse_end -> IDLE after 5000 cycles with drain_timeout_err=1, cleared by next host_start.
REQ-041 host_start and host_stop in the same cycle in IDLE -> remains IDLE.
REQ-042 rst_n low mid-RUN -> all outputs at reset values; with PULSE_STAT_EN, 10 pulses -> pulse_count=10.
